// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NREQ word producers.
// Frame: 4 raw data bytes (or 8 ASCII hex chars with UART_ARB_HEX_EN), source-ID byte, CR.
module uart_frame_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter logic [7:0]  ID_BASE = 8'h30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic [15:0]        frame_count
);

`ifdef UART_ARB_HEX_EN
  localparam int unsigned NBYTES = 10;
`else
  localparam int unsigned NBYTES = 6;
`endif
  localparam int unsigned IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  logic [31:0]     data_q, data_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [31:0]     win_data;
  logic            transfer;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte i of the frame carrying word d from requester id.
  function automatic logic [7:0] frame_byte(input logic [31:0] d, input logic [IDW-1:0] id,
                                            input logic [IDXW-1:0] i);
    logic [7:0] b;
    b = 8'h0D;
`ifdef UART_ARB_HEX_EN
    if (i < IDXW'(8)) begin
      b = hex_char(4'(d >> (5'd28 - 5'({i[2:0], 2'b00}))));
    end else if (i == IDXW'(8)) begin
      b = ID_BASE + 8'(id);
    end
`else
    if (i < IDXW'(4)) begin
      b = 8'(d >> (5'd24 - 5'({i[1:0], 3'b000})));
    end else if (i == IDXW'(4)) begin
      b = ID_BASE + 8'(id);
    end
`endif
    return b;
  endfunction

  // Round-robin winner: first valid index above last, else first valid at or below it.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req_valid[j] && (j > 32'(last_q))) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req_valid[j] && (j <= 32'(last_q))) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (IDW'(j) == win) win_data = req_data[32*j +: 32];
    end
  end

  assign transfer  = (state_q == IDLE) && found;
  assign req_ready = transfer ? (NREQ'(1) << win) : '0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    grant_d       = grant_q;
    last_d        = last_q;
    idx_d         = idx_q;
    busy_d        = busy_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d    = SEND;
          data_d     = win_data;
          grant_d    = win;
          last_d     = win;
          idx_d      = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(win_data, win, '0);
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d       = IDLE;
            idx_d         = '0;
            busy_d        = 1'b0;
            tx_valid_d    = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            idx_d     = idx_q + IDXW'(1);
            tx_data_d = frame_byte(data_q, grant_q, idx_q + IDXW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      grant_q       <= '0;
      last_q        <= LAST_RST;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: frame contents, round robin, backpressure, reset, wrap.
module tb_uart_frame_arbiter;
  localparam int NREQ = 4;
`ifdef UART_ARB_HEX_EN
  localparam int NB = 10;
`else
  localparam int NB = 6;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic [1:0]         grant_id;
  logic [15:0]        frame_count;

  always #5 clk = ~clk;

  uart_frame_arbiter #(.NREQ(NREQ), .IDW(2), .ID_BASE(8'h30)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id), .frame_count(frame_count)
  );

  typedef struct {
    int          req;
    logic [31:0] data;
    int          period;
    logic [7:0]  exp[10];
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] got[10];
  int         got_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Accept bytes with tx_ready high one cycle in 'period'; checks held bytes stay stable.
  task automatic collect(input int period, input int maxn);
    int         cyc = 0;
    logic       held = 1'b0;
    logic [7:0] hv = '0;
    got_n = 0;
    while (got_n < maxn && cyc < 400) begin
      if (tx_valid) begin
        if (held) chk("tx_stable", 32'(tx_data), 32'(hv));
        if ((cyc % period) == 0) begin
          tx_ready = 1'b1;
          got[got_n] = tx_data;
          got_n++;
          held = 1'b0;
        end else begin
          tx_ready = 1'b0;
          held = 1'b1;
          hv = tx_data;
        end
      end else begin
        tx_ready = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    chk("byte_count", 32'(got_n), 32'(maxn));
  endtask

  task automatic run_frame(input int req, input logic [31:0] data, input int period,
                           input logic [7:0] e[10], input logic [15:0] ecnt);
    req_data[32*req +: 32] = data;
    req_valid = 4'(1 << req);
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(1 << req));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    req_data[32*req +: 32] = ~data;
    chk("req_ready_after", 32'(req_ready), 32'd0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    collect(period, NB);
    for (int i = 0; i < NB; i++) chk($sformatf("byte%0d_req%0d", i, req), 32'(got[i]), 32'(e[i]));
    chk("tx_valid_end", 32'(tx_valid), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("frame_count", 32'(frame_count), 32'(ecnt));
    chk("grant_id", 32'(grant_id), 32'(req));
  endtask

  vec_t       vecs[4];
  int         nvec;
  logic [7:0] ew[10];
  logic [7:0] er[10];
  int         order[5];

  initial begin
`ifdef UART_ARB_HEX_EN
    nvec = 2;
    vecs[0] = '{req: 1, data: 32'h00A1FF09, period: 1,
                exp: '{8'h30, 8'h30, 8'h41, 8'h31, 8'h46, 8'h46, 8'h30, 8'h39, 8'h31, 8'h0D}};
    vecs[1] = '{req: 0, data: 32'hDEADBEEF, period: 3,
                exp: '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h30, 8'h0D}};
    vecs[2] = vecs[1];
    vecs[3] = vecs[1];
    ew = '{8'h35, 8'h35, 8'h41, 8'h41, 8'h35, 8'h35, 8'h41, 8'h41, 8'h30, 8'h0D};
    er = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44, 8'h32, 8'h0D};
`else
    nvec = 4;
    vecs[0] = '{req: 0, data: 32'hDEADBEEF, period: 1,
                exp: '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h30, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{req: 3, data: 32'h12345678, period: 3,
                exp: '{8'h12, 8'h34, 8'h56, 8'h78, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{req: 1, data: 32'h0102A0FF, period: 2,
                exp: '{8'h01, 8'h02, 8'hA0, 8'hFF, 8'h31, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{req: 2, data: 32'h00000000, period: 1,
                exp: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h32, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}};
    ew = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h30, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
    er = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h32, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;

    // tx_ready in IDLE has no effect
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_tx_valid", 32'(tx_valid), 32'd0);
    chk("idle_ready_count", 32'(frame_count), 32'd0);
    tx_ready = 1'b0;

    // Valid withdrawn before the edge: nothing granted
    req_valid = 4'b0010;
    #1;
    chk("withdraw_req_ready", 32'(req_ready), 32'h2);
    #2;
    req_valid = '0;
    @(negedge clk);
    chk("withdraw_grant_id", 32'(grant_id), 32'd0);
    chk("withdraw_busy", 32'(busy), 32'd0);
    chk("withdraw_tx_valid", 32'(tx_valid), 32'd0);

    for (int v = 0; v < nvec; v++)
      run_frame(vecs[v].req, vecs[v].data, vecs[v].period, vecs[v].exp, 16'(v + 1));

    // Counter wrap
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    chk("wrap_preload", 32'(frame_count), 32'h0000FFFF);
    run_frame(0, 32'h55AA55AA, 1, ew, 16'h0000);

    // Round robin with all requesters continuously valid
    do_reset();
    req_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      collect(1, NB);
      chk($sformatf("rr_id_byte%0d", f), 32'(got[NB-2]), 32'(8'h30 + 8'(order[f])));
      chk($sformatf("rr_grant%0d", f), 32'(grant_id), 32'(order[f]));
      chk($sformatf("rr_gap%0d", f), 32'(tx_valid), 32'd0);
    end
    req_valid = '0;
    chk("rr_count", 32'(frame_count), 32'd5);

    // Reset mid-frame, then the still-pending request is sent whole
    do_reset();
    req_data[95:64] = 32'hCAFEF00D;
    req_valid = 4'b0100;
    collect(1, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    collect(1, NB);
    req_valid = '0;
    for (int i = 0; i < NB; i++) chk($sformatf("midrst_byte%0d", i), 32'(got[i]), 32'(er[i]));
    chk("midrst_after_count", 32'(frame_count), 32'd1);
    chk("midrst_grant", 32'(grant_id), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
